usb_tx_packet_serializer: RTL and testbench
===========================================

# usb_tx_packet_serializer

Full-speed USB packet transmitter for the SIE transmit path. Each clk48 cycle it can accept one byte from the packet backend: the PID first, then the payload bytes. It frames the bytes with SYNC, appends CRC16 to data packets, applies bit stuffing and NRZI encoding, and terminates the packet with EOP. It drives the differential-pair output registers at 12 Mbit/s from a single 48 MHz clock and is the transmit counterpart of the packet receiver.

## Interface
- No parameters.
- clk48  input  1  48 MHz system clock; the only clock.
- RST_N  input  1  asynchronous, active-low reset.
- txReqSendPacket  input  1  pulse that starts a packet; sampled only in IDLE.
- txDataValid  input  1  txData and txIsLastByte are valid.
- txData  input  8  byte to send: PID first, then payload.
- txIsLastByte  input  1  marks the current txData byte as the final byte of the packet.
- txAcceptNewData  output  1  one-byte holding buffer is free.
- sending  output  1  a packet is on the line, from SYNC through the end of EOP.
- dataOutP_reg  output  1  D+ drive value.
- dataOutN_reg  output  1  D- drive value.

## Operation
- **Bit tick:** a free-running 2-bit counter, cleared by reset, produces bitTick when it equals 3. Line outputs change only on a bitTick cycle, so one bit time is 4 clk48 cycles.
- **Holding buffer:** 8-bit data plus a last flag.
  - A byte is written when txDataValid && txAcceptNewData.
  - txAcceptNewData = buffer empty && last byte not yet accepted in this packet. It is also high in IDLE, so the PID can be preloaded.
- **States:** IDLE → SYNC → DATA → CRC → EOP → IDLE, plus ABORT.
  - **IDLE:** line is J (P=1, N=0) and sending=0. txReqSendPacket=1 moves to SYNC on the next cycle.
  - **SYNC:** shifts 0x80 LSb first (0000_0001). On the bitTick that sends the SYNC's last bit, the buffer moves to the shift register and the state becomes DATA.
  - **DATA:**
    - After each byte's 8th bit, if the finished byte was last: go to CRC when the PID satisfies PID[1:0]==2'b11, otherwise go to EOP.
    - If the finished byte was not last, reload the shift register from the buffer.
    - If the buffer is empty when a reload is needed, go to ABORT (underrun).
  - **CRC:**
    - Polynomial 0x8005 (x^16+x^15+x^2+1), initial value 0xFFFF, computed over the payload bytes only (the PID is excluded), LSb first.
    - Sends the one's complement as 16 bits, bit 0 first.
  - **EOP:** SE0 (P=0, N=0) for 2 bit times, then J for 1 bit time, then IDLE.
  - **ABORT:** sends 7 NRZI '1' bits (line held) with stuffing suppressed, then goes to EOP.
- **Bit stuffing:**
  - The ones counter is cleared at the start of SYNC and on every 0 bit.
  - After 6 consecutive 1 bits, a 0 is inserted and the shift register stalls for that bit time.
  - Stuffing applies to SYNC, DATA and CRC, including a stuff bit owed after the final CRC bit, which is sent before EOP.
- **NRZI:** the line state starts at J when SYNC begins. A 0 bit toggles J/K; a 1 bit holds the line.
- The buffer is held during stuff bits.

## Timing
- **Reset values:** dataOutP_reg=1, dataOutN_reg=0, sending=0, txAcceptNewData=1, state=IDLE, buffer empty, bit counter=0.
- **Reset mid-packet:** the line returns to J immediately and asynchronously, with no EOP.
- **Packet start:** sending rises in the cycle after the request is accepted. The first SYNC bit appears at the next bitTick, 1 to 4 cycles after the request.
- **Packet end:** sending falls in the cycle after the EOP J bit time ends.
- **Buffer refill:** the buffer frees one cycle after it loads into the shift register. The backend then has at least 7 bit times (28 cycles) to supply the next byte.
- **Ignored inputs:**
  - txReqSendPacket is ignored outside IDLE.
  - A write offered after the last byte was accepted is ignored, because txAcceptNewData is 0.
- **Request with empty buffer:** txReqSendPacket with an empty buffer is legal. If the PID has not arrived by the end of SYNC, the block goes to ABORT.
- **Simultaneous load and refill:** a buffer write in the same cycle as a shift-register load is accepted, because txAcceptNewData was already high in that cycle.

## Test plan
- **ACK handshake:**
  - Stimulus: preload 0xD2 with last=1, then pulse the request.
  - Required response: P/N shows KJKJKJKK, then PID bits 0,1,0,0,1,0,1,1 NRZI-encoded, then SE0, SE0, J. Exactly 19 bit times (76 cycles). sending is high throughout. No CRC is sent.
- **Zero-length DATA0:**
  - Stimulus: 0xC3 with last=1.
  - Required response: CRC field of 16 zero bits (line toggling every bit), 35 bit times total.
- **Bit stuffing:**
  - Stimulus: DATA1 0x4B, then payload 0xFF with last=1.
  - Required response: a stuffed 0 appears after the 6th one of 0xFF. Decoded and unstuffed bits match a reference model. Any stuff bits owed in the CRC are checked against the model.
- **Underrun:**
  - Stimulus: PID 0xC3 (not last), with no further byte supplied.
  - Required response: after the PID, the line holds for 7 bit times, then SE0, SE0, J, and sending falls.
- **Backpressure:**
  - Stimulus: 4-byte DATA0 payload 00 01 02 03, with each byte offered 20 cycles after txAcceptNewData rises.
  - Required response: no gaps on the line, and the CRC matches the model.
- **Reset mid-CRC:**
  - Stimulus: drop RST_N during the CRC field.
  - Required response: outputs go immediately to P=1, N=0, sending=0, txAcceptNewData=1. A new ACK sent after reset is bit-exact.

Source files
------------

// File: rtl/usb_tx_packet_serializer_if.sv
// Backend-to-transmitter byte stream interface for the USB full-speed serializer.
//   txReqSendPacket  : backend -> serializer, pulse that starts a packet (honoured in idle only)
//   txDataValid      : backend -> serializer, txData/txIsLastByte are valid
//   txData           : backend -> serializer, PID first, then payload bytes
//   txIsLastByte     : backend -> serializer, current byte closes the packet
//   txAcceptNewData  : serializer -> backend, one-byte holding buffer can take a byte
//   sending          : serializer -> backend, packet on the line (SYNC through end of EOP)
interface usb_tx_packet_serializer_if;
    logic       txReqSendPacket;
    logic       txDataValid;
    logic [7:0] txData;
    logic       txIsLastByte;
    logic       txAcceptNewData;
    logic       sending;

    modport master (
        output txReqSendPacket,
        output txDataValid,
        output txData,
        output txIsLastByte,
        input  txAcceptNewData,
        input  sending
    );

    modport slave (
        input  txReqSendPacket,
        input  txDataValid,
        input  txData,
        input  txIsLastByte,
        output txAcceptNewData,
        output sending
    );
endinterface

// File: rtl/usb_tx_packet_serializer.sv
// Full-speed USB packet transmitter. Frames backend bytes with SYNC, appends CRC16 to data
// packets, bit-stuffs, NRZI-encodes and closes with EOP. One bit time = 4 clk48 cycles.
//   clk48        : 48 MHz clock
//   RST_N        : asynchronous active-low reset (line forced to J, no EOP)
//   tx_bus       : byte stream handshake from the packet backend (slave side)
//   dataOutP_reg : registered D+ drive value
//   dataOutN_reg : registered D- drive value
module usb_tx_packet_serializer (
    input  logic                             clk48,
    input  logic                             RST_N,
    usb_tx_packet_serializer_if.slave        tx_bus,
    output logic                             dataOutP_reg,
    output logic                             dataOutN_reg
);

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StData,
        StCrc,
        StEop,
        StAbort
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [7:0]  buf_data_q, buf_data_d;
    logic        buf_last_q, buf_last_d;
    logic        buf_full_q, buf_full_d;
    logic        last_acc_q, last_acc_d;
    logic [7:0]  shift_q, shift_d;
    logic        shift_last_q, shift_last_d;
    logic        is_pid_q, is_pid_d;
    logic        pid_data_q, pid_data_d;
    logic [3:0]  bit_idx_q, bit_idx_d;
    logic [1:0]  eop_cnt_q, eop_cnt_d;
    logic [2:0]  ones_q, ones_d;
    logic [15:0] crc_q, crc_d;
    logic        line_j_q, line_j_d;
    logic        out_p_q, out_p_d;
    logic        out_n_q, out_n_d;

    logic        bit_tick;
    logic        accept;
    logic        wr_en;
    logic        stuff;
    logic        ser_bit;
    logic        crc_fb;
    logic [15:0] crc_next;
    logic        tx_en;
    logic        tx_bit;
    logic        load;

    assign bit_tick = (cnt_q == 2'd3);
    assign accept   = !buf_full_q && !last_acc_q;
    assign wr_en    = tx_bus.txDataValid && accept;
    assign stuff    = (ones_q == 3'd6);
    assign ser_bit  = (state_q == StCrc) ? !crc_q[0] : shift_q[0];

    // CRC register kept bit-reversed (0xA001 is 0x8005 reflected) so that bit 0 leaves first.
    assign crc_fb   = ser_bit ^ crc_q[0];
    assign crc_next = {1'b0, crc_q[15:1]} ^ (crc_fb ? 16'hA001 : 16'h0000);

    assign tx_bus.txAcceptNewData = accept;
    assign tx_bus.sending         = (state_q != StIdle);
    assign dataOutP_reg           = out_p_q;
    assign dataOutN_reg           = out_n_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 2'd1;
        buf_data_d   = buf_data_q;
        buf_last_d   = buf_last_q;
        buf_full_d   = buf_full_q;
        last_acc_d   = last_acc_q;
        shift_d      = shift_q;
        shift_last_d = shift_last_q;
        is_pid_d     = is_pid_q;
        pid_data_d   = pid_data_q;
        bit_idx_d    = bit_idx_q;
        eop_cnt_d    = eop_cnt_q;
        ones_d       = ones_q;
        crc_d        = crc_q;
        line_j_d     = line_j_q;
        out_p_d      = out_p_q;
        out_n_d      = out_n_q;
        tx_en        = 1'b0;
        tx_bit       = 1'b0;
        load         = 1'b0;

        case (state_q)
            StIdle: begin
                if (tx_bus.txReqSendPacket) begin
                    state_d   = StSync;
                    shift_d   = 8'h80;
                    bit_idx_d = 4'd0;
                    ones_d    = 3'd0;
                    line_j_d  = 1'b1;
                    crc_d     = 16'hFFFF;
                end
            end

            StSync, StData, StCrc: begin
                if (bit_tick) begin
                    tx_en = 1'b1;
                    if (stuff) begin
                        // Stuffed zero: nothing advances, buffer and shifter hold.
                        tx_bit = 1'b0;
                        ones_d = 3'd0;
                    end else begin
                        tx_bit    = ser_bit;
                        ones_d    = ser_bit ? ones_q + 3'd1 : 3'd0;
                        bit_idx_d = bit_idx_q + 4'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        if (state_q == StCrc) begin
                            crc_d = {1'b1, crc_q[15:1]};
                            if (bit_idx_q == 4'd15) begin
                                state_d   = StEop;
                                eop_cnt_d = 2'd0;
                                bit_idx_d = 4'd0;
                            end
                        end else begin
                            if (state_q == StData && !is_pid_q) begin
                                crc_d = crc_next;
                            end
                            if (bit_idx_q == 4'd7) begin
                                bit_idx_d = 4'd0;
                                is_pid_d  = 1'b0;
                                if (state_q == StData && shift_last_q) begin
                                    state_d   = pid_data_q ? StCrc : StEop;
                                    eop_cnt_d = 2'd0;
                                end else if (buf_full_q) begin
                                    load    = 1'b1;
                                    state_d = StData;
                                    if (state_q == StSync) begin
                                        is_pid_d   = 1'b1;
                                        pid_data_d = &buf_data_q[1:0];
                                    end
                                end else begin
                                    // Underrun: abort with stuffing suppressed.
                                    state_d = StAbort;
                                    ones_d  = 3'd0;
                                end
                            end
                        end
                    end
                end
            end

            StAbort: begin
                if (bit_tick) begin
                    tx_en     = 1'b1;
                    tx_bit    = 1'b1;
                    bit_idx_d = bit_idx_q + 4'd1;
                    if (bit_idx_q == 4'd6) begin
                        state_d   = StEop;
                        eop_cnt_d = 2'd0;
                        bit_idx_d = 4'd0;
                    end
                end
            end

            StEop: begin
                if (bit_tick) begin
                    if (eop_cnt_q == 2'd0 && stuff) begin
                        // Stuff bit still owed after the last field bit.
                        tx_en  = 1'b1;
                        tx_bit = 1'b0;
                        ones_d = 3'd0;
                    end else begin
                        eop_cnt_d = eop_cnt_q + 2'd1;
                        case (eop_cnt_q)
                            2'd0, 2'd1: begin
                                out_p_d = 1'b0;
                                out_n_d = 1'b0;
                            end
                            2'd2: begin
                                out_p_d = 1'b1;
                                out_n_d = 1'b0;
                            end
                            default: begin
                                state_d    = StIdle;
                                last_acc_d = 1'b0;
                                eop_cnt_d  = 2'd0;
                            end
                        endcase
                    end
                end
            end

            default: state_d = StIdle;
        endcase

        if (load) begin
            shift_d      = buf_data_q;
            shift_last_d = buf_last_q;
            buf_full_d   = 1'b0;
        end

        if (wr_en) begin
            buf_data_d = tx_bus.txData;
            buf_last_d = tx_bus.txIsLastByte;
            buf_full_d = 1'b1;
            if (tx_bus.txIsLastByte) begin
                last_acc_d = 1'b1;
            end
        end

        // NRZI: zero toggles J/K, one holds the line.
        if (tx_en) begin
            line_j_d = tx_bit ? line_j_q : !line_j_q;
            out_p_d  = line_j_d;
            out_n_d  = !line_j_d;
        end
    end

    always_ff @(posedge clk48 or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= StIdle;
            cnt_q        <= 2'd0;
            buf_data_q   <= 8'h00;
            buf_last_q   <= 1'b0;
            buf_full_q   <= 1'b0;
            last_acc_q   <= 1'b0;
            shift_q      <= 8'h00;
            shift_last_q <= 1'b0;
            is_pid_q     <= 1'b0;
            pid_data_q   <= 1'b0;
            bit_idx_q    <= 4'd0;
            eop_cnt_q    <= 2'd0;
            ones_q       <= 3'd0;
            crc_q        <= 16'hFFFF;
            line_j_q     <= 1'b1;
            out_p_q      <= 1'b1;
            out_n_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            buf_data_q   <= buf_data_d;
            buf_last_q   <= buf_last_d;
            buf_full_q   <= buf_full_d;
            last_acc_q   <= last_acc_d;
            shift_q      <= shift_d;
            shift_last_q <= shift_last_d;
            is_pid_q     <= is_pid_d;
            pid_data_q   <= pid_data_d;
            bit_idx_q    <= bit_idx_d;
            eop_cnt_q    <= eop_cnt_d;
            ones_q       <= ones_d;
            crc_q        <= crc_d;
            line_j_q     <= line_j_d;
            out_p_q      <= out_p_d;
            out_n_q      <= out_n_d;
        end
    end

endmodule

// File: tb/tb_usb_tx_packet_serializer.sv
// Directed bench for usb_tx_packet_serializer: samples the line once per bit time and compares
// against hand-written J/K/SE0 strings or a small serial packet model.
module tb_usb_tx_packet_serializer;

    logic clk48 = 1'b0;
    logic RST_N = 1'b0;
    logic dp;
    logic dn;

    always #5 clk48 = ~clk48;

    usb_tx_packet_serializer_if tx_bus ();

    usb_tx_packet_serializer dut (
        .clk48        (clk48),
        .RST_N        (RST_N),
        .tx_bus       (tx_bus),
        .dataOutP_reg (dp),
        .dataOutN_reg (dn)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Posedges since reset release; bit ticks land on multiples of 4.
    int cyc;
    always @(posedge clk48 or negedge RST_N) begin
        if (!RST_N) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    logic       cap_en    = 1'b0;
    logic       send_prev = 1'b0;
    logic [1:0] rec_q[$];
    logic [1:0] exp_q[$];
    int         first_cyc = -1;
    int         fall_cyc  = -1;

    always @(negedge clk48) begin
        if (RST_N && cap_en) begin
            if ((cyc % 4) == 0 && send_prev && tx_bus.sending) begin
                if (rec_q.size() == 0) first_cyc = cyc;
                rec_q.push_back({dp, dn});
            end
            if (send_prev && !tx_bus.sending) fall_cyc = cyc;
        end
        send_prev = tx_bus.sending;
    end

    function automatic logic [1:0] line_code(input byte c);
        if (c == "J")      return 2'b10;
        else if (c == "K") return 2'b01;
        else               return 2'b00;
    endfunction

    task automatic set_exp_str(input string s);
        exp_q.delete();
        for (int i = 0; i < s.len(); i++) exp_q.push_back(line_code(s[i]));
    endtask

    byte pkt[8];

    // Serial reference: SYNC + bytes (+ CRC16 for data PIDs), stuff, NRZI, EOP.
    task automatic model_packet(input int n);
        bit          b_q[$];
        bit          s_q[$];
        logic [15:0] crc;
        logic        fb;
        int          ones;
        logic        j;
        for (int i = 0; i < 8; i++) b_q.push_back(i == 7);
        for (int k = 0; k < n; k++)
            for (int i = 0; i < 8; i++) b_q.push_back(pkt[k][i]);
        if (pkt[0][1:0] == 2'b11) begin
            // Non-reflected 0x8005 form: its bit 15 is the first bit on the wire.
            crc = 16'hFFFF;
            for (int k = 1; k < n; k++)
                for (int i = 0; i < 8; i++) begin
                    fb  = pkt[k][i] ^ crc[15];
                    crc = {crc[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
                end
            for (int i = 0; i < 16; i++) b_q.push_back(!crc[15-i]);
        end
        ones = 0;
        foreach (b_q[i]) begin
            s_q.push_back(b_q[i]);
            if (b_q[i]) begin
                ones++;
                if (ones == 6) begin
                    s_q.push_back(1'b0);
                    ones = 0;
                end
            end else begin
                ones = 0;
            end
        end
        exp_q.delete();
        j = 1'b1;
        foreach (s_q[i]) begin
            if (!s_q[i]) j = !j;
            exp_q.push_back(j ? 2'b10 : 2'b01);
        end
        exp_q.push_back(2'b00);
        exp_q.push_back(2'b00);
        exp_q.push_back(2'b10);
    endtask

    task automatic write_byte(input logic [7:0] d, input logic last, input int delay);
        int n = 0;
        @(negedge clk48);
        while (!tx_bus.txAcceptNewData && n < 400) begin
            @(negedge clk48);
            n++;
        end
        if (n >= 400) check_eq("accept_timeout", {31'd0, tx_bus.txAcceptNewData}, 32'd1);
        repeat (delay) @(negedge clk48);
        tx_bus.txDataValid  = 1'b1;
        tx_bus.txData       = d;
        tx_bus.txIsLastByte = last;
        @(negedge clk48);
        tx_bus.txDataValid  = 1'b0;
        tx_bus.txIsLastByte = 1'b0;
    endtask

    task automatic start_capture();
        rec_q.delete();
        first_cyc = -1;
        fall_cyc  = -1;
        cap_en    = 1'b1;
    endtask

    task automatic pulse_req();
        @(negedge clk48);
        tx_bus.txReqSendPacket = 1'b1;
        @(negedge clk48);
        tx_bus.txReqSendPacket = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (fall_cyc < 0 && n < 3000) begin
            @(negedge clk48);
            n++;
        end
        if (fall_cyc < 0) check_eq({tag, "_done"}, {31'd0, tx_bus.sending}, 32'd0);
        cap_en = 1'b0;
        repeat (3) @(negedge clk48);
    endtask

    task automatic compare_line(input string tag);
        int n;
        check_eq({tag, "_len"}, rec_q.size(), exp_q.size());
        n = (rec_q.size() < exp_q.size()) ? rec_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check_eq($sformatf("%s_b%0d", tag, i), {30'd0, rec_q[i]}, {30'd0, exp_q[i]});
    endtask

    initial begin
        tx_bus.txReqSendPacket = 1'b0;
        tx_bus.txDataValid     = 1'b0;
        tx_bus.txData          = 8'h00;
        tx_bus.txIsLastByte    = 1'b0;

        repeat (3) @(negedge clk48);
        check_eq("rst_p", {31'd0, dp}, 32'd1);
        check_eq("rst_n", {31'd0, dn}, 32'd0);
        check_eq("rst_sending", {31'd0, tx_bus.sending}, 32'd0);
        check_eq("rst_accept", {31'd0, tx_bus.txAcceptNewData}, 32'd1);
        RST_N = 1'b1;
        repeat (5) @(negedge clk48);

        // ACK handshake, with a stray request mid-packet that must be ignored.
        write_byte(8'hD2, 1'b1, 0);
        check_eq("ack_accept_full", {31'd0, tx_bus.txAcceptNewData}, 32'd0);
        start_capture();
        pulse_req();
        repeat (30) @(negedge clk48);
        tx_bus.txReqSendPacket = 1'b1;
        @(negedge clk48);
        tx_bus.txReqSendPacket = 1'b0;
        wait_done("ack");
        set_exp_str("KJKJKJKKJJKJJKKK00J");
        compare_line("ack");
        check_eq("ack_cycles", fall_cyc - first_cyc, 32'd76);
        check_eq("ack_idle_sending", {31'd0, tx_bus.sending}, 32'd0);
        check_eq("ack_idle_accept", {31'd0, tx_bus.txAcceptNewData}, 32'd1);

        // Zero-length DATA0: CRC field is sixteen zeros.
        write_byte(8'hC3, 1'b1, 0);
        start_capture();
        pulse_req();
        wait_done("zlp");
        set_exp_str("KJKJKJKKKKJKJKKKJKJKJKJKJKJKJKJK00J");
        compare_line("zlp");

        // Bit stuffing inside a 0xFF payload byte.
        pkt[0] = 8'h4B;
        pkt[1] = 8'hFF;
        model_packet(2);
        write_byte(8'h4B, 1'b0, 0);
        start_capture();
        pulse_req();
        write_byte(8'hFF, 1'b1, 0);
        wait_done("stuff");
        compare_line("stuff");
        if (rec_q.size() > 22) begin
            check_eq("stuff_pre", {30'd0, rec_q[21]}, 32'd1);
            check_eq("stuff_bit", {30'd0, rec_q[22]}, 32'd2);
        end else begin
            check_eq("stuff_short", rec_q.size(), 32'd23);
        end

        // Underrun after a non-last PID.
        write_byte(8'hC3, 1'b0, 0);
        start_capture();
        pulse_req();
        wait_done("urun");
        set_exp_str("KJKJKJKKKKJKJKKKKKKKKKK00J");
        compare_line("urun");

        // Backpressure: each payload byte offered 20 cycles after the buffer frees.
        pkt[0] = 8'hC3;
        pkt[1] = 8'h00;
        pkt[2] = 8'h01;
        pkt[3] = 8'h02;
        pkt[4] = 8'h03;
        model_packet(5);
        write_byte(8'hC3, 1'b0, 0);
        start_capture();
        pulse_req();
        for (int k = 0; k < 4; k++) write_byte(pkt[k+1], (k == 3), 20);
        check_eq("bp_accept_after_last", {31'd0, tx_bus.txAcceptNewData}, 32'd0);
        tx_bus.txDataValid  = 1'b1;
        tx_bus.txData       = 8'hAA;
        tx_bus.txIsLastByte = 1'b1;
        @(negedge clk48);
        tx_bus.txDataValid  = 1'b0;
        tx_bus.txIsLastByte = 1'b0;
        wait_done("bp");
        compare_line("bp");

        // Reset in the middle of the CRC field.
        write_byte(8'hC3, 1'b1, 0);
        start_capture();
        pulse_req();
        begin
            int n = 0;
            while (rec_q.size() < 22 && n < 500) begin
                @(negedge clk48);
                n++;
            end
            check_eq("mid_crc_reached", (rec_q.size() >= 22), 32'd1);
        end
        cap_en = 1'b0;
        #2;
        RST_N = 1'b0;
        #1;
        check_eq("mrst_p", {31'd0, dp}, 32'd1);
        check_eq("mrst_n", {31'd0, dn}, 32'd0);
        check_eq("mrst_sending", {31'd0, tx_bus.sending}, 32'd0);
        check_eq("mrst_accept", {31'd0, tx_bus.txAcceptNewData}, 32'd1);
        @(negedge clk48);
        RST_N = 1'b1;
        repeat (3) @(negedge clk48);
        write_byte(8'hD2, 1'b1, 0);
        start_capture();
        pulse_req();
        wait_done("ack2");
        set_exp_str("KJKJKJKKJJKJJKKK00J");
        compare_line("ack2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
